// File: rtl/fifo_rd_serializer_if.sv
// Handshake bundle between the FIFO read port, the serializer and the beat consumer.
// The slave modport is the serializer's view; master is the surrounding environment.
`timescale 1ns/1ps
interface fifo_rd_serializer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_W     = 16
);
  logic                 i_fifo_empty;
  logic [IN_WIDTH-1:0]  i_fifo_rddata;
  logic                 o_fifo_rden;
  logic                 o_valid;
  logic                 i_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_last;
  logic                 i_flush;
  logic                 o_busy;
  logic [CNT_W-1:0]     o_word_cnt;

  modport slave (
    input  i_fifo_empty, i_fifo_rddata, i_ready, i_flush,
    output o_fifo_rden, o_valid, o_data, o_last, o_busy, o_word_cnt
  );

  modport master (
    output i_fifo_empty, i_fifo_rddata, i_ready, i_flush,
    input  o_fifo_rden, o_valid, o_data, o_last, o_busy, o_word_cnt
  );
endinterface

// File: rtl/fifo_rd_serializer.sv
// Drains a synchronous FIFO one wide word at a time and replays it as
// narrower valid/ready beats, least-significant slice first.
`timescale 1ns/1ps
module fifo_rd_serializer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_rd_serializer_if.slave  bus
);
  localparam int BEATS  = IN_WIDTH / OUT_WIDTH;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   beat_cnt_q;
  logic [IN_WIDTH-1:0] word_q;
  logic [CNT_W-1:0]    word_cnt_q;
  logic                rden;
  logic                xfer;
  logic                at_last;

  assign at_last = (beat_cnt_q == LAST_BEAT);
  assign xfer    = (state_q == SEND) && bus.i_ready;

  always_comb begin
    state_d = state_q;
    rden    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.i_fifo_empty && !bus.i_flush) begin
          rden    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        // Pop the next word on the last beat so only one bubble separates words.
        if (xfer && at_last) begin
          if (!bus.i_fifo_empty && !bus.i_flush) begin
            rden    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q <= '0;
    end else if (bus.i_flush || state_q == FETCH) begin
      beat_cnt_q <= '0;
    end else if (xfer) begin
      beat_cnt_q <= at_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // FIFO read data is valid the cycle after the pop, i.e. during FETCH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 word_q <= '0;
    else if (state_q == FETCH) word_q <= bus.i_fifo_rddata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                word_cnt_q <= '0;
    else if (xfer && at_last) word_cnt_q <= word_cnt_q + 1'b1;
  end

  // The rden term is gated so the pop request stays low while reset is held.
  assign bus.o_fifo_rden = rden && rstn;
  assign bus.o_valid     = (state_q == SEND);
  assign bus.o_last      = (state_q == SEND) && at_last;
  assign bus.o_data      = (state_q == SEND) ? word_q[beat_cnt_q*OUT_WIDTH +: OUT_WIDTH]
                                             : '0;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: a FIFO model drives the read port, and a
// beat-queue reference predicts every output each cycle.
`timescale 1ns/1ps
module tb_fifo_rd_serializer;
  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int CNT_W = 16;
  localparam int BEATS = IN_W / OUT_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fifo_rd_serializer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_W(CNT_W)) bus_if ();

  fifo_rd_serializer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] fifo_q[$];
  int pops_req  = 0;
  int pops_done = 0;

  beat_t            mq[$];
  logic             fetching = 1'b0;
  logic [IN_W-1:0]  fetch_word = '0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int cyc_n = 0, rden_cnt = 0, hi_cnt = 0, stall07_cnt = 0;
  logic [OUT_W-1:0] obs_data[$];
  logic             obs_last[$];
  int               obs_cyc[$];
  int               rden_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] obs_at(input int i);
    if (i >= 0 && i < obs_data.size()) return obs_data[i];
    return 'x;
  endfunction

  function automatic logic obs_last_at(input int i);
    if (i >= 0 && i < obs_last.size()) return obs_last[i];
    return 1'bx;
  endfunction

  function automatic int obs_cyc_at(input int i);
    if (i >= 0 && i < obs_cyc.size()) return obs_cyc[i];
    return -1000;
  endfunction

  function automatic int rden_cyc_at(input int i);
    if (i >= 0 && i < rden_cyc.size()) return rden_cyc[i];
    return -2000;
  endfunction

  // Reference: popped words become a queue of expected beats; outputs follow from it.
  always @(negedge clk) begin : compare
    logic             exp_valid, exp_busy, exp_last, exp_rden;
    logic [OUT_W-1:0] exp_data;
    cyc_n++;
    if (!rstn) begin
      mq.delete();
      fetching = 1'b0;
      exp_cnt  = '0;
      chk("rst_valid", 64'(bus_if.o_valid), 64'(0));
      chk("rst_busy",  64'(bus_if.o_busy), 64'(0));
      chk("rst_rden",  64'(bus_if.o_fifo_rden), 64'(0));
      chk("rst_data",  64'(bus_if.o_data), 64'(0));
      chk("rst_last",  64'(bus_if.o_last), 64'(0));
      chk("rst_cnt",   64'(bus_if.o_word_cnt), 64'(0));
    end else begin
      exp_valid = (mq.size() != 0);
      exp_busy  = fetching || exp_valid;
      exp_data  = exp_valid ? mq[0].data : '0;
      exp_last  = exp_valid && mq[0].last;
      exp_rden  = !bus_if.i_fifo_empty && !bus_if.i_flush &&
                  (!exp_busy || (exp_last && bus_if.i_ready));
      chk("cyc_rden",  64'(bus_if.o_fifo_rden), 64'(exp_rden));
      chk("cyc_valid", 64'(bus_if.o_valid), 64'(exp_valid));
      chk("cyc_busy",  64'(bus_if.o_busy), 64'(exp_busy));
      chk("cyc_data",  64'(bus_if.o_data), 64'(exp_data));
      chk("cyc_last",  64'(bus_if.o_last), 64'(exp_last));
      chk("cyc_cnt",   64'(bus_if.o_word_cnt), 64'(exp_cnt));

      if (bus_if.o_fifo_rden) begin
        rden_cnt++;
        rden_cyc.push_back(cyc_n);
        if (fifo_q.size() > 0) pops_req++;
      end
      if (bus_if.o_valid || bus_if.o_busy || bus_if.o_fifo_rden) hi_cnt++;
      if (bus_if.o_valid && bus_if.o_data == 32'h07060504) stall07_cnt++;
      if (bus_if.o_valid && bus_if.i_ready) begin
        obs_data.push_back(bus_if.o_data);
        obs_last.push_back(bus_if.o_last);
        obs_cyc.push_back(cyc_n);
      end

      if (exp_valid && bus_if.i_ready) begin
        if (mq[0].last) exp_cnt++;
        void'(mq.pop_front());
      end
      if (bus_if.i_flush) begin
        mq.delete();
        fetching = 1'b0;
      end else if (fetching) begin
        for (int i = 0; i < BEATS; i++) begin
          beat_t b;
          b.data = fetch_word[i*OUT_W +: OUT_W];
          b.last = (i == BEATS - 1);
          mq.push_back(b);
        end
        fetching = 1'b0;
      end
      if (exp_rden && fifo_q.size() > 0) begin
        fetching   = 1'b1;
        fetch_word = fifo_q[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    while (pops_done < pops_req) begin
      if (fifo_q.size() > 0) bus_if.i_fifo_rddata = fifo_q.pop_front();
      pops_done++;
    end
    bus_if.i_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [IN_W-1:0] w);
    fifo_q.push_back(w);
    bus_if.i_fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus_if.i_ready = 1'b1;
    bus_if.i_flush = 1'b0;
    fifo_q.delete();
    bus_if.i_fifo_empty = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 30 && obs_data.size() < n; k++) tick();
  endtask

  localparam logic [IN_W-1:0] W0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [IN_W-1:0] W1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [OUT_W-1:0] t1_exp [BEATS];
    int base, rc0, r0, s0, h0;
    t1_exp = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    bus_if.i_fifo_empty  = 1'b1;
    bus_if.i_fifo_rddata = '0;
    bus_if.i_ready       = 1'b1;
    bus_if.i_flush       = 1'b0;

    // Single word, consumer always ready
    do_reset();
    base = obs_data.size(); rc0 = rden_cyc.size(); r0 = rden_cnt;
    push(W0);
    repeat (10) tick();
    chk("t1_beats", 64'(obs_data.size() - base), 64'(4));
    for (int i = 0; i < BEATS; i++) begin
      chk($sformatf("t1_beat%0d", i), 64'(obs_at(base + i)), 64'(t1_exp[i]));
      chk($sformatf("t1_last%0d", i), 64'(obs_last_at(base + i)), 64'(i == BEATS - 1));
    end
    chk("t1_rden", 64'(rden_cnt - r0), 64'(1));
    chk("t1_latency", 64'(obs_cyc_at(base) - rden_cyc_at(rc0)), 64'(2));
    chk("t1_cnt", 64'(bus_if.o_word_cnt), 64'(1));
    chk("t1_idle", 64'(bus_if.o_busy), 64'(0));

    // Consumer stalls three cycles on beat 2
    do_reset();
    base = obs_data.size(); r0 = rden_cnt; s0 = stall07_cnt;
    push(W0);
    wait_beats(base + 1);
    bus_if.i_ready = 1'b0;
    repeat (3) tick();
    bus_if.i_ready = 1'b1;
    repeat (10) tick();
    chk("t2_hold", 64'(stall07_cnt - s0), 64'(4));
    chk("t2_beats", 64'(obs_data.size() - base), 64'(4));
    chk("t2_beat1", 64'(obs_at(base + 1)), 64'(32'h07060504));
    chk("t2_rden", 64'(rden_cnt - r0), 64'(1));

    // Two queued words back to back
    do_reset();
    base = obs_data.size(); rc0 = rden_cyc.size(); r0 = rden_cnt;
    push(W0);
    push(W1);
    repeat (16) tick();
    chk("t3_beats", 64'(obs_data.size() - base), 64'(8));
    chk("t3_bubble", 64'(obs_cyc_at(base + 4) - obs_cyc_at(base + 3)), 64'(2));
    chk("t3_rden_on_last", 64'(rden_cyc_at(rc0 + 1) - obs_cyc_at(base + 3)), 64'(0));
    chk("t3_w1_beat0", 64'(obs_at(base + 4)), 64'(32'h13121110));
    chk("t3_rden", 64'(rden_cnt - r0), 64'(2));
    chk("t3_cnt", 64'(bus_if.o_word_cnt), 64'(2));

    // Empty FIFO keeps everything quiet
    h0 = hi_cnt;
    repeat (20) tick();
    chk("t4_quiet", 64'(hi_cnt - h0), 64'(0));

    // Flush after the first beat, next word queued during the flush
    do_reset();
    base = obs_data.size();
    push(W0);
    wait_beats(base + 1);
    bus_if.i_flush = 1'b1;
    push(W1);
    tick();
    bus_if.i_flush = 1'b0;
    chk("t5_valid_off", 64'(bus_if.o_valid), 64'(0));
    repeat (10) tick();
    chk("t5_beats", 64'(obs_data.size() - base), 64'(6));
    chk("t5_next_beat0", 64'(obs_at(base + 2)), 64'(32'h13121110));
    chk("t5_cnt", 64'(bus_if.o_word_cnt), 64'(1));

    // Asynchronous reset in the middle of a word
    base = obs_data.size();
    push(W0);
    wait_beats(base + 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("t6_valid", 64'(bus_if.o_valid), 64'(0));
    chk("t6_data", 64'(bus_if.o_data), 64'(0));
    chk("t6_last", 64'(bus_if.o_last), 64'(0));
    chk("t6_busy", 64'(bus_if.o_busy), 64'(0));
    chk("t6_cnt", 64'(bus_if.o_word_cnt), 64'(0));
    repeat (2) tick();
    rstn = 1'b1;
    base = obs_data.size();
    push(W1);
    repeat (10) tick();
    chk("t6_restart_beats", 64'(obs_data.size() - base), 64'(4));
    chk("t6_restart_beat0", 64'(obs_at(base)), 64'(32'h13121110));
    chk("t6_restart_cnt", 64'(bus_if.o_word_cnt), 64'(1));

    // Randomized traffic: arrivals, back-pressure and occasional flushes
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2, 0) == 0 && fifo_q.size() < 6)
        push({$urandom(), $urandom(), $urandom(), $urandom()});
      bus_if.i_ready = ($urandom_range(3, 0) != 0);
      bus_if.i_flush = ($urandom_range(24, 0) == 0);
      tick();
    end
    bus_if.i_flush = 1'b0;
    bus_if.i_ready = 1'b1;
    repeat (60) tick();
    chk("drain_fifo", 64'(fifo_q.size()), 64'(0));
    chk("drain_busy", 64'(bus_if.o_busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
